// File: rtl/uart_arb_pkg.sv
// Shared encodings and width helpers for the UART transmit arbiter and its
// round-robin picker.
package uart_arb_pkg;
    localparam int BYTE_W = 8;

    typedef logic [1:0] arb_state_t;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // The idle counter only has to reach IDLE_TIMEOUT-1.
    function automatic int idle_cnt_w(input int idle_timeout);
        return (idle_timeout < 2) ? 1 : $clog2(idle_timeout);
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the UART tx handshake; the arbiter is the slave,
// requesters and UART together form the master side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import uart_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_valid;
    logic                      tx_ack;

    modport master (
        output req_valid, req_data, req_last, tx_ack,
        input  req_ready, tx_data, tx_valid
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ack,
        output req_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request strictly after
// i_last, wrapping around, with i_last itself considered last.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        // Scan farthest-first so the nearest candidate after i_last wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(i_last) + k) % NUM_REQ);
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte streams: round-robin grant
// locked per packet, one-byte holding register feeding the UART handshake.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int MAX_BURST    = 64,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               spurious_ack
);
    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int BW    = burst_cnt_w(MAX_BURST);
    localparam int IW    = idle_cnt_w(IDLE_TIMEOUT);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last_owner;
    logic [BYTE_W-1:0]  r_hold;
    logic               r_hold_full;
    logic               r_last_flag;
    logic               r_spurious;
    logic [BW-1:0]      r_burst_cnt;
    logic [IW-1:0]      r_idle_cnt;

    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_found;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic               w_owner_valid;
    logic               w_owner_last;
    logic [BYTE_W-1:0]  w_owner_data;
    logic               w_accept;
    logic               w_ack;
    logic               w_idle_cond;
    logic               w_timeout;
    logic [BW-1:0]      w_burst_nxt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_last  (r_last_owner),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_owner_oh    = NUM_REQ'(1) << r_owner;
    assign w_owner_valid = bus.req_valid[r_owner];
    assign w_owner_last  = bus.req_last[r_owner];
    assign w_owner_data  = bus.req_data[BYTE_W*r_owner +: BYTE_W];

    assign w_accept    = (r_state == ST_LOCKED) && !r_hold_full && w_owner_valid;
    assign w_ack       = bus.tx_ack && r_hold_full;
    assign w_idle_cond = !r_hold_full && !w_owner_valid;
    assign w_timeout   = (r_state == ST_LOCKED) && !w_owner_valid &&
                         (r_idle_cnt == IW'(IDLE_TIMEOUT - 1));
    assign w_burst_nxt = r_burst_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_last_flag  <= 1'b0;
            r_spurious   <= 1'b0;
            r_burst_cnt  <= '0;
            r_idle_cnt   <= '0;
        end else begin
            if (bus.tx_ack && !r_hold_full) begin
                r_spurious <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        r_owner     <= w_pick_idx;
                        r_burst_cnt <= '0;
                        r_idle_cnt  <= '0;
                        r_state     <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_accept) begin
                        r_hold      <= w_owner_data;
                        r_hold_full <= 1'b1;
                        r_burst_cnt <= w_burst_nxt;
                        r_last_flag <= w_owner_last || (w_burst_nxt == BW'(MAX_BURST));
                    end
                    if (w_ack) begin
                        r_hold_full <= 1'b0;
                    end
                    r_idle_cnt <= w_idle_cond ? r_idle_cnt + 1'b1 : '0;
                    // Release on the packet's final ack, or when the owner goes quiet.
                    if (w_ack && r_last_flag) begin
                        r_state      <= ST_IDLE;
                        r_last_owner <= r_owner;
                    end else if (w_timeout) begin
                        r_state      <= (r_hold_full && !w_ack) ? ST_DRAIN : ST_IDLE;
                        r_last_owner <= r_owner;
                    end
                end
                ST_DRAIN: begin
                    if (w_ack) begin
                        r_hold_full <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx_valid  = r_hold_full;
    assign bus.tx_data   = r_hold;
    assign bus.req_ready = ((r_state == ST_LOCKED) && !r_hold_full) ? w_owner_oh : '0;
    assign grant         = (r_state != ST_IDLE) ? w_owner_oh : '0;
    assign busy          = (r_state != ST_IDLE) || r_hold_full;
    assign spurious_ack  = r_spurious;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte-stream requesters, e.g. the emulator debug stream and the display/status reporter. Round-robin arbitration picks an owner, and the grant stays locked for a packet, ending on a last-flagged byte, a burst cap or an idle timeout. A one-byte holding register drives the UART's tx_data_i/tx_ready_i pair and is consumed by its tx_ack_o pulse. Sits in top between the requesters and the UART instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MAX_BURST, 64, max bytes per grant before forced release (1..255)
IDLE_TIMEOUT, 1024, cycles the owner may leave req_valid low (with holding reg empty) before release (1..65535)

Ports:
clk  in  1  system clock (100 MHz domain)
rst  in  1  reset; synchronous, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  byte for requester i at [8*i+7:8*i]
req_last  in  NUM_REQ  byte is final of packet
req_ready  out  NUM_REQ  byte accepted when valid&ready
tx_data  out  8  byte to UART tx_data_i
tx_valid  out  1  to UART tx_ready_i; byte pending
tx_ack  in  1  UART tx_ack_o; one-cycle pulse, byte taken
grant  out  NUM_REQ  one-hot current owner, 0 when idle
busy  out  1  grant locked or holding reg full
spurious_ack  out  1  sticky: tx_ack seen while tx_valid low

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state IDLE, grant 0, req_ready 0, tx_valid 0, tx_data 0, busy 0, spurious_ack 0, burst_cnt 0, idle_cnt 0, last_owner NUM_REQ-1 (requester 0 wins first). A reset mid-byte drops the pending byte; no ack is awaited afterwards.
- FSM states: IDLE, LOCKED, DRAIN.
- IDLE:
  - If any req_valid, choose the first valid index scanning from last_owner+1 mod NUM_REQ upward with wrap.
  - Register owner, clear burst_cnt and idle_cnt, go to LOCKED. Grant becomes visible the next cycle.
  - No byte is accepted in IDLE.
- LOCKED:
  - req_ready[owner] = !hold_full (combinational). All other req_ready are 0.
  - On accept: hold <= data, hold_full <= 1, burst_cnt++, last_flag <= req_last | (burst_cnt+1 == MAX_BURST).
  - tx_valid = hold_full (registered). Byte accepted at cycle N gives tx_valid high at N+1; tx_data stays stable until ack.
  - On tx_ack with tx_valid high: hold_full <= 0. If last_flag, go to IDLE, last_owner <= owner, grant <= 0.
  - Next byte is accepted no earlier than the cycle after the ack, so tx_valid is low for at least 1 cycle between bytes.
  - Idle timeout: while hold_full == 0 and req_valid[owner] == 0, idle_cnt increments; otherwise it clears. At idle_cnt == IDLE_TIMEOUT-1, go to IDLE and rotate last_owner.
- DRAIN: entered if the timeout fires while hold_full (unreachable by definition; kept for safety). Wait for tx_ack, then go to IDLE.
- spurious_ack: tx_ack while tx_valid == 0 sets it. Cleared only by rst. Otherwise ignored.
- Non-owner req_valid has no effect. Requesters must hold data stable while valid&!ready.
- busy = (state != IDLE) | hold_full.
- Simultaneous events: an ack and a new request from another requester in the same cycle → release happens first; the new request is arbitrated in IDLE the next cycle.
- Packet-boundary fairness: a requester never gets two consecutive grants while another requester is valid in IDLE.

Decomposition:
- Shared package uart_arb_pkg holds:
  - state encoding (IDLE/LOCKED/DRAIN)
  - BYTE_W = 8
  - counter widths derived via $clog2(MAX_BURST+1) and $clog2(IDLE_TIMEOUT)
- One natural sub-module: rr_pick. Combinational round-robin priority encoder: inputs req vector + last_owner, outputs index + found. Reused later for ROM-port sharing.

Test Plan:
- Single req0 packet 0x41,0x42(last) with ack 3 cycles after each tx_valid rise → tx_data 0x41 then 0x42, grant=01 throughout, returns IDLE, grant=00 one cycle after 2nd ack.
- req0 and req1 both valid in IDLE after reset → req0 granted first. After its last byte, req1 granted even though req0 still valid. Third grant goes back to req0.
- MAX_BURST=4, req1 streams 10 bytes with no last → grant released after 4th ack; req0 (valid) gets the next grant; req1 resumes afterwards.
- Owner req0 sends one non-last byte then drops valid → release exactly IDLE_TIMEOUT cycles after the ack; req1 then granted.
- rst asserted while tx_valid high with 0x55 pending → next cycle tx_valid 0, grant 0, busy 0. A later ack pulse sets spurious_ack=1.
- tx_ack pulse in IDLE → spurious_ack=1 and stays 1 until rst; no state change.
